// File: rtl/pixel_order_scaler.sv
// rtl/pixel_order_scaler.sv - two-stage pixel channel reorder and brightness scaler
//
// Purpose: accepts one pixel per valid/ready handshake. Stage 1 maps every output
// slot to an input channel through orderIN; stage 2 scales each slot by
// (brightness + 1) >> BW. At most two pixels are in flight.
//
// Ports:
//   clkIN, rstIN         clock, asynchronous active-high reset
//   dataIN/lastIN        input pixel (channel 0 in the LSBs) and end-of-frame flag
//   validIN/readyOUT     input handshake
//   orderIN/brightIN     slot map and brightness, sampled with the pixel
//   dataOUT/lastOUT      reordered, scaled pixel and its frame flag
//   validOUT/readyIN     output handshake
module pixel_order_scaler #(
   parameter int CHANNELS = 3,
   parameter int CW       = 8,
   parameter int BW       = 8,
   parameter int IW       = 3
) (
   input  logic                   clkIN,
   input  logic                   rstIN,
   input  logic [CHANNELS*CW-1:0] dataIN,
   input  logic                   lastIN,
   input  logic                   validIN,
   output logic                   readyOUT,
   input  logic [CHANNELS*IW-1:0] orderIN,
   input  logic [BW-1:0]          brightIN,
   output logic [CHANNELS*CW-1:0] dataOUT,
   output logic                   lastOUT,
   output logic                   validOUT,
   input  logic                   readyIN
);

   logic                   r_v1;
   logic [CHANNELS*CW-1:0] r_data1;
   logic [BW-1:0]          r_bright1;
   logic                   r_last1;

   logic                   r_v2;
   logic [CHANNELS*CW-1:0] r_data2;
   logic                   r_last2;

   logic                   w_ready1;
   logic                   w_ready2;
   logic [CHANNELS*CW-1:0] w_reorder;
   logic [CHANNELS*CW-1:0] w_scaled;

   // Each stage advances on its own enable so a full pipeline still moves
   // one pixel per cycle when downstream drains every cycle.
   assign w_ready2 = !r_v2 || readyIN;
   assign w_ready1 = !r_v1 || w_ready2;
   assign readyOUT = w_ready1;

   // Slots whose index names no existing channel keep the default of zero.
   always_comb begin
      w_reorder = '0;
      for (int s = 0; s < CHANNELS; s++) begin
         for (int k = 0; k < CHANNELS; k++) begin
            if (orderIN[s*IW +: IW] == IW'(k)) begin
               w_reorder[s*CW +: CW] = dataIN[k*CW +: CW];
            end
         end
      end
   end

   // Multiplying by (b + 1) lets full brightness pass data unchanged after the
   // shift; the product never reaches its top bit, and the low BW bits are
   // the discarded fraction.
   genvar g;
   for (g = 0; g < CHANNELS; g++) begin : g_scale
      logic [CW+BW:0] w_prod;
      logic           w_unused_bits;
      assign w_prod = {{(BW+1){1'b0}}, r_data1[g*CW +: CW]} *
                      {{CW{1'b0}}, ({1'b0, r_bright1} + {{BW{1'b0}}, 1'b1})};
      assign w_scaled[g*CW +: CW] = w_prod[BW +: CW];
      assign w_unused_bits = ^{w_prod[CW+BW], w_prod[BW-1:0]};
   end

   always_ff @(posedge clkIN or posedge rstIN) begin
      if (rstIN) begin
         r_v1      <= 1'b0;
         r_data1   <= '0;
         r_bright1 <= '0;
         r_last1   <= 1'b0;
         r_v2      <= 1'b0;
         r_data2   <= '0;
         r_last2   <= 1'b0;
      end else begin
         if (w_ready1) begin
            r_v1      <= validIN;
            r_data1   <= w_reorder;
            r_bright1 <= brightIN;
            r_last1   <= validIN && lastIN;
         end
         if (w_ready2) begin
            r_v2    <= r_v1;
            r_data2 <= w_scaled;
            r_last2 <= r_last1;
         end
      end
   end

   assign dataOUT  = r_data2;
   assign lastOUT  = r_last2;
   assign validOUT = r_v2;

endmodule
